// File: rtl/l2_bridge.sv
// l2_bridge: moves whole 128-bit cache lines between the L1 controller and a
// 32-bit word-wide memory port. Write-backs go out as four write beats; fills
// go out as four read beats and the returning words are assembled into
// fill_line. Every output comes straight from a register.
module l2_bridge #(
   parameter int LINE_WORDS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      read_l2,
   input  logic                      write_l2,
   input  logic [31:0]               line_addr,
   input  logic [31:0]               victim_addr,
   input  logic [32*LINE_WORDS-1:0]  wb_line,
   output logic                      l2_ack,
   output logic                      write_done,
   output logic [32*LINE_WORDS-1:0]  fill_line,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic                      mem_gnt,
   input  logic                      mem_rvalid,
   input  logic [31:0]               mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_REQ,
      READ_DATA,
      RESP_W,
      RESP_R
   } state_t;

   state_t                     state, state_n;
   logic [27:0]                base, base_n;
   logic [32*LINE_WORDS-1:0]   wb_buf, wb_buf_n;
   logic [1:0]                 cnt, cnt_n;
   logic [1:0]                 rcnt, rcnt_n;
   logic                       l2_ack_n, write_done_n;
   logic                       mem_req_n, mem_we_n;
   logic [31:0]                mem_addr_n, mem_wdata_n;
   logic [32*LINE_WORDS-1:0]   fill_n;

   logic                       granted;
   logic [1:0]                 cnt_inc;
   logic                       unused_addr_bits;

   // The low four address bits select a byte within the line and are not needed.
   assign unused_addr_bits = ^{victim_addr[3:0], line_addr[3:0]};
   assign granted = mem_req && mem_gnt;
   assign cnt_inc = cnt + 2'd1;

   // State, counters, captured request and all output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         base       <= '0;
         wb_buf     <= '0;
         cnt        <= '0;
         rcnt       <= '0;
         l2_ack     <= 1'b0;
         write_done <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         fill_line  <= '0;
      end else begin
         state      <= state_n;
         base       <= base_n;
         wb_buf     <= wb_buf_n;
         cnt        <= cnt_n;
         rcnt       <= rcnt_n;
         l2_ack     <= l2_ack_n;
         write_done <= write_done_n;
         mem_req    <= mem_req_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         fill_line  <= fill_n;
      end
   end

   // Next-state and next-output decode; the outputs are computed one edge ahead
   // so the memory side sees each beat in the first cycle of its state.
   always_comb begin
      state_n      = state;
      base_n       = base;
      wb_buf_n     = wb_buf;
      cnt_n        = cnt;
      rcnt_n       = rcnt;
      l2_ack_n     = 1'b0;
      write_done_n = 1'b0;
      mem_req_n    = mem_req;
      mem_we_n     = mem_we;
      mem_addr_n   = mem_addr;
      mem_wdata_n  = mem_wdata;
      fill_n       = fill_line;

      case (state)
         IDLE: begin
            if (write_l2) begin
               base_n      = victim_addr[31:4];
               wb_buf_n    = wb_line;
               cnt_n       = 2'd0;
               state_n     = WRITE;
               mem_req_n   = 1'b1;
               mem_we_n    = 1'b1;
               mem_addr_n  = {victim_addr[31:4], 4'b0000};
               mem_wdata_n = wb_line[31:0];
            end else if (read_l2) begin
               base_n      = line_addr[31:4];
               cnt_n       = 2'd0;
               rcnt_n      = 2'd0;
               state_n     = READ_REQ;
               mem_req_n   = 1'b1;
               mem_we_n    = 1'b0;
               mem_addr_n  = {line_addr[31:4], 4'b0000};
               mem_wdata_n = 32'd0;
            end
         end

         WRITE: begin
            if (granted) begin
               if (cnt == 2'd3) begin
                  state_n      = RESP_W;
                  write_done_n = 1'b1;
                  mem_req_n    = 1'b0;
                  mem_we_n     = 1'b0;
                  mem_addr_n   = 32'd0;
                  mem_wdata_n  = 32'd0;
               end else begin
                  cnt_n       = cnt_inc;
                  mem_addr_n  = {base, cnt_inc, 2'b00};
                  mem_wdata_n = wb_buf[{cnt_inc, 5'd0} +: 32];
               end
            end
         end

         READ_REQ: begin
            if (granted) begin
               if (cnt == 2'd3) begin
                  state_n    = READ_DATA;
                  mem_req_n  = 1'b0;
                  mem_addr_n = 32'd0;
               end else begin
                  cnt_n      = cnt_inc;
                  mem_addr_n = {base, cnt_inc, 2'b00};
               end
            end
            if (mem_rvalid && (rcnt != 2'd3)) begin
               fill_n[{rcnt, 5'd0} +: 32] = mem_rdata;
               rcnt_n = rcnt + 2'd1;
            end
         end

         READ_DATA: begin
            if (mem_rvalid) begin
               fill_n[{rcnt, 5'd0} +: 32] = mem_rdata;
               if (rcnt == 2'd3) begin
                  state_n  = RESP_R;
                  l2_ack_n = 1'b1;
                  rcnt_n   = 2'd0;
               end else begin
                  rcnt_n = rcnt + 2'd1;
               end
            end
         end

         RESP_W: state_n = IDLE;

         RESP_R: state_n = IDLE;

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_l2_bridge.sv
// Directed testbench for l2_bridge: write-back, fill, grant stall, dirty miss,
// stray read data and reset during a fill.
module tb_l2_bridge;

   logic          clk;
   logic          reset;
   logic          read_l2;
   logic          write_l2;
   logic [31:0]   line_addr;
   logic [31:0]   victim_addr;
   logic [127:0]  wb_line;
   logic          l2_ack;
   logic          write_done;
   logic [127:0]  fill_line;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   l2_bridge #(.LINE_WORDS(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .read_l2     (read_l2),
      .write_l2    (write_l2),
      .line_addr   (line_addr),
      .victim_addr (victim_addr),
      .wb_line     (wb_line),
      .l2_ack      (l2_ack),
      .write_done  (write_done),
      .fill_line   (fill_line),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; read_l2 = 1'b0; write_l2 = 1'b0; line_addr = '0; victim_addr = '0;
      wb_line = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      n_checks++;
      if ({l2_ack, write_done, mem_req, mem_we} !== 4'b0000)
         $display("[TB] FAIL rst_flags: got %b want 0000", {l2_ack, write_done, mem_req, mem_we});
      else n_pass++;
      n_checks++;
      if ({mem_addr, mem_wdata} !== 64'd0)
         $display("[TB] FAIL rst_bus: got %h want 0", {mem_addr, mem_wdata});
      else n_pass++;
      n_checks++;
      if (fill_line !== 128'd0) $display("[TB] FAIL rst_fill: got %h want 0", fill_line);
      else n_pass++;
   endtask

   task automatic test_write_back();
      victim_addr = 32'h0000_1234;
      wb_line = {32'h44, 32'h33, 32'h22, 32'h11};
      mem_gnt = 1'b1;
      write_l2 = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({mem_req, mem_we, write_done} !== 3'b110)
            $display("[TB] FAIL wb_flags%0d: got %b want 110", k, {mem_req, mem_we, write_done});
         else n_pass++;
         n_checks++;
         if (mem_addr !== 32'h1230 + 32'(4 * k))
            $display("[TB] FAIL wb_addr%0d: got %h want %h", k, mem_addr, 32'h1230 + 32'(4 * k));
         else n_pass++;
         n_checks++;
         if (mem_wdata !== 32'h11 * 32'(k + 1))
            $display("[TB] FAIL wb_data%0d: got %h want %h", k, mem_wdata, 32'h11 * 32'(k + 1));
         else n_pass++;
         tick();
      end
      n_checks++;
      if ({write_done, mem_req} !== 2'b10)
         $display("[TB] FAIL wb_done: got %b want 10", {write_done, mem_req});
      else n_pass++;
      write_l2 = 1'b0;
      tick();
      n_checks++;
      if ({write_done, mem_req} !== 2'b00)
         $display("[TB] FAIL wb_done_once: got %b want 00", {write_done, mem_req});
      else n_pass++;
   endtask

   task automatic test_stall();
      logic        gnt_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int          idx_seq [7] = '{0, 1, 1, 1, 1, 2, 3};
      victim_addr = 32'h0000_ABC8;
      wb_line = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      mem_gnt = 1'b1;
      write_l2 = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         mem_gnt = gnt_seq[i];
         n_checks++;
         if ({mem_req, mem_we, write_done} !== 3'b110)
            $display("[TB] FAIL st_flags%0d: got %b want 110", i, {mem_req, mem_we, write_done});
         else n_pass++;
         n_checks++;
         if (mem_addr !== 32'hABC0 + 32'(4 * idx_seq[i]))
            $display("[TB] FAIL st_addr%0d: got %h want %h", i, mem_addr, 32'hABC0 + 32'(4 * idx_seq[i]));
         else n_pass++;
         n_checks++;
         if (mem_wdata !== 32'hD0 + 32'(idx_seq[i]))
            $display("[TB] FAIL st_data%0d: got %h want %h", i, mem_wdata, 32'hD0 + 32'(idx_seq[i]));
         else n_pass++;
         tick();
      end
      n_checks++;
      if ({write_done, mem_req} !== 2'b10)
         $display("[TB] FAIL st_done: got %b want 10", {write_done, mem_req});
      else n_pass++;
      write_l2 = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      logic        req_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] adr_seq [5] = '{32'h8000, 32'h8004, 32'h8008, 32'h800C, 32'h0};
      logic        rv_seq  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] rd_seq  [5] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
      line_addr = 32'h0000_8008;
      mem_gnt = 1'b1;
      read_l2 = 1'b1;
      tick();
      for (int c = 0; c < 5; c++) begin
         mem_rvalid = rv_seq[c];
         mem_rdata = rd_seq[c];
         n_checks++;
         if ({mem_req, mem_we, l2_ack} !== {req_seq[c], 2'b00})
            $display("[TB] FAIL fi_flags%0d: got %b want %b", c, {mem_req, mem_we, l2_ack}, {req_seq[c], 2'b00});
         else n_pass++;
         if (req_seq[c]) begin
            n_checks++;
            if (mem_addr !== adr_seq[c])
               $display("[TB] FAIL fi_addr%0d: got %h want %h", c, mem_addr, adr_seq[c]);
            else n_pass++;
         end
         tick();
      end
      mem_rvalid = 1'b0;
      n_checks++;
      if (l2_ack !== 1'b1) $display("[TB] FAIL fi_ack: got %b want 1", l2_ack);
      else n_pass++;
      n_checks++;
      if (fill_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0})
         $display("[TB] FAIL fi_line: got %h want %h", fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      else n_pass++;
      read_l2 = 1'b0;
      tick();
      n_checks++;
      if ({l2_ack, mem_req} !== 2'b00) $display("[TB] FAIL fi_ack_once: got %b want 00", {l2_ack, mem_req});
      else n_pass++;
      n_checks++;
      if (fill_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0})
         $display("[TB] FAIL fi_hold: got %h want %h", fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      else n_pass++;
   endtask

   task automatic test_dirty_miss();
      logic        rv_seq [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] rd_seq [5] = '{32'h0, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
      victim_addr = 32'h0000_2000;
      line_addr = 32'h0000_3000;
      wb_line = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      mem_gnt = 1'b1;
      write_l2 = 1'b1;
      read_l2 = 1'b1;
      tick();
      n_checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'h2000})
         $display("[TB] FAIL dm_write_first: got %b %h want 11 00002000", {mem_req, mem_we}, mem_addr);
      else n_pass++;
      tick(); tick(); tick(); tick();
      n_checks++;
      if (write_done !== 1'b1) $display("[TB] FAIL dm_wdone: got %b want 1", write_done);
      else n_pass++;
      write_l2 = 1'b0;
      tick();
      n_checks++;
      if ({mem_req, write_done} !== 2'b00) $display("[TB] FAIL dm_idle: got %b want 00", {mem_req, write_done});
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h3000})
         $display("[TB] FAIL dm_read_start: got %b %h want 10 00003000", {mem_req, mem_we}, mem_addr);
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         mem_rvalid = rv_seq[c];
         mem_rdata = rd_seq[c];
         n_checks++;
         if (l2_ack !== 1'b0) $display("[TB] FAIL dm_early_ack%0d: got %b want 0", c, l2_ack);
         else n_pass++;
         tick();
      end
      mem_rvalid = 1'b0;
      n_checks++;
      if ({l2_ack, fill_line} !== {1'b1, 32'hC3, 32'hC2, 32'hC1, 32'hC0})
         $display("[TB] FAIL dm_fill: got %b %h want 1 %h", l2_ack, fill_line, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      else n_pass++;
      read_l2 = 1'b0;
      tick();
   endtask

   task automatic test_stray_rvalid();
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_rvalid = 1'b0;
      n_checks++;
      if (fill_line !== {32'hC3, 32'hC2, 32'hC1, 32'hC0})
         $display("[TB] FAIL stray_fill: got %h want %h", fill_line, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      else n_pass++;
      n_checks++;
      if ({l2_ack, write_done, mem_req} !== 3'b000)
         $display("[TB] FAIL stray_pulse: got %b want 000", {l2_ack, write_done, mem_req});
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      line_addr = 32'h0000_4000;
      mem_gnt = 1'b1;
      read_l2 = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hE0;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hE1;
      reset = 1'b1;
      tick();
      n_checks++;
      if ({l2_ack, write_done, mem_req, mem_we, mem_addr, mem_wdata} !== 68'd0)
         $display("[TB] FAIL ra_outputs: got %b %h %h want 0", {l2_ack, write_done, mem_req, mem_we}, mem_addr, mem_wdata);
      else n_pass++;
      n_checks++;
      if (fill_line !== 128'd0) $display("[TB] FAIL ra_fill: got %h want 0", fill_line);
      else n_pass++;
      reset = 1'b0;
      read_l2 = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({l2_ack, mem_req, fill_line} !== {2'b00, 128'd0})
            $display("[TB] FAIL ra_late%0d: got %b %h want 00 0", i, {l2_ack, mem_req}, fill_line);
         else n_pass++;
         tick();
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_write_back();
      test_stall();
      test_fill();
      test_dirty_miss();
      test_stray_rvalid();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
